// File: rtl/psum_gbf_pkg.sv
// Shared types and constants for the partial-sum global buffer sequencer.
// Holds the accumulate and drain FSM encodings and the bank-select values
// driven on psum_gbf_w_num.
package psum_gbf_pkg;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_RUN,
    ACC_SWAP_WAIT,
    ACC_FLUSH
  } acc_state_e;

  typedef enum logic {
    D_IDLE,
    D_RUN
  } drain_state_e;

  localparam logic BANK1 = 1'b0;
  localparam logic BANK2 = 1'b1;

endpackage

// File: rtl/psum_gbf_ctrl_if.sv
// Bundle of the job-config, psum-beat, bank-control and drain signals between
// the sequencer and its surroundings (PE array, psum_gbf_wrapper, output side).
//   master : the sequencer (drives psum_ready, bank enables/addresses, status)
//   slave  : the environment (drives start/cfg, psum_valid, drain_ready)
interface psum_gbf_ctrl_if #(
  parameter int unsigned PSUM_GBF_ADDR_BITWIDTH = 5,
  parameter int unsigned PASS_CNT_BITWIDTH      = 8,
  parameter int unsigned TILE_CNT_BITWIDTH      = 8
);
  logic                              start;
  logic [PSUM_GBF_ADDR_BITWIDTH:0]   cfg_tile_len;
  logic [PASS_CNT_BITWIDTH-1:0]      cfg_num_pass;
  logic [TILE_CNT_BITWIDTH-1:0]      cfg_num_tile;
  logic                              psum_valid;
  logic                              psum_ready;
  logic                              r_en1b;
  logic                              r_en2b;
  logic [PSUM_GBF_ADDR_BITWIDTH-1:0] r_addr1b;
  logic [PSUM_GBF_ADDR_BITWIDTH-1:0] r_addr2b;
  logic                              w_en1a;
  logic                              w_en2a;
  logic [PSUM_GBF_ADDR_BITWIDTH-1:0] w_addr;
  logic                              acc_first;
  logic                              psum_gbf_w_num;
  logic                              drain_ready;
  logic                              r_en1b_out;
  logic                              r_en2b_out;
  logic                              drain_valid;
  logic                              busy;
  logic                              done;

  modport master (
    input  start, cfg_tile_len, cfg_num_pass, cfg_num_tile, psum_valid, drain_ready,
    output psum_ready, r_en1b, r_en2b, r_addr1b, r_addr2b, w_en1a, w_en2a, w_addr,
           acc_first, psum_gbf_w_num, r_en1b_out, r_en2b_out, drain_valid, busy, done
  );

  modport slave (
    output start, cfg_tile_len, cfg_num_pass, cfg_num_tile, psum_valid, drain_ready,
    input  psum_ready, r_en1b, r_en2b, r_addr1b, r_addr2b, w_en1a, w_en2a, w_addr,
           acc_first, psum_gbf_w_num, r_en1b_out, r_en2b_out, drain_valid, busy, done
  );
endinterface

// File: rtl/psum_gbf_drain_seq.sv
// Drain sequencer: walks addresses 0..tile_len-1 of the completed bank,
// issuing one read per cycle that drain_ready is high, and flags each read
// with drain_valid one cycle later (matching the SRAM read latency).
//   clk_i, rst_ni   : clock, async active-low reset
//   start_i         : begin a drain (accepted when idle or on the final read)
//   tile_len_i      : number of addresses to drain
//   drain_ready_i   : downstream can take a word next cycle
//   rd_en_o/addr_o  : drain read request and address
//   last_o          : this cycle's read is the final address
//   busy_o          : drain in progress
//   drain_valid_o   : read data valid (one cycle after rd_en_o)
module psum_gbf_drain_seq
  import psum_gbf_pkg::*;
#(
  parameter int unsigned PSUM_GBF_ADDR_BITWIDTH = 5
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              start_i,
  input  logic [PSUM_GBF_ADDR_BITWIDTH:0]   tile_len_i,
  input  logic                              drain_ready_i,
  output logic                              rd_en_o,
  output logic [PSUM_GBF_ADDR_BITWIDTH-1:0] rd_addr_o,
  output logic                              last_o,
  output logic                              busy_o,
  output logic                              drain_valid_o
);
  localparam int unsigned LW = PSUM_GBF_ADDR_BITWIDTH + 1;

  drain_state_e                      state_q, state_d;
  logic [PSUM_GBF_ADDR_BITWIDTH-1:0] d_ptr_q, d_ptr_d;
  logic                              valid_q, valid_d;

  always_comb begin
    rd_en_o = (state_q == D_RUN) && drain_ready_i;
    last_o  = rd_en_o && ({1'b0, d_ptr_q} == (tile_len_i - LW'(1)));
    state_d = state_q;
    d_ptr_d = d_ptr_q;
    valid_d = rd_en_o;
    if (rd_en_o) begin
      if (last_o) begin
        d_ptr_d = '0;
        state_d = D_IDLE;
      end else begin
        d_ptr_d = d_ptr_q + 1'b1;
      end
    end
    // A start on the final read chains straight into the next bank's drain.
    if (start_i) begin
      state_d = D_RUN;
      d_ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= D_IDLE;
      d_ptr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      d_ptr_q <= d_ptr_d;
      valid_q <= valid_d;
    end
  end

  assign rd_addr_o     = d_ptr_q;
  assign busy_o        = (state_q == D_RUN);
  assign drain_valid_o = valid_q;

endmodule

// File: rtl/psum_gbf_ctrl.sv
// Sequencer for the double-buffered partial-sum global buffer.
// Accepts psum beats from the PE array and steers them into the accumulate
// bank as read (cycle t) / write (cycle t+1), counting addresses, passes and
// tiles. When a tile completes the banks ping-pong via psum_gbf_w_num and the
// completed bank is drained to the output side by psum_gbf_drain_seq.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : psum_gbf_ctrl_if master modport (config, beats, bank controls, drain, status)
module psum_gbf_ctrl
  import psum_gbf_pkg::*;
#(
  parameter int unsigned PSUM_GBF_ADDR_BITWIDTH = 5,
  parameter int unsigned PSUM_GBF_DEPTH         = 32,
  parameter int unsigned PASS_CNT_BITWIDTH      = 8,
  parameter int unsigned TILE_CNT_BITWIDTH      = 8
) (
  input  logic            clk,
  input  logic            reset,
  psum_gbf_ctrl_if.master bus
);
  localparam int unsigned AW = PSUM_GBF_ADDR_BITWIDTH;
  localparam int unsigned LW = AW + 1;
  localparam int unsigned PW = PASS_CNT_BITWIDTH;
  localparam int unsigned TW = TILE_CNT_BITWIDTH;

  acc_state_e        state_q, state_d;
  logic [LW-1:0]     tile_len_q, tile_len_d;
  logic [PW-1:0]     num_pass_q, num_pass_d, pass_cnt_q, pass_cnt_d;
  logic [TW-1:0]     num_tile_q, num_tile_d, tile_cnt_q, tile_cnt_d;
  logic [AW-1:0]     acc_ptr_q, acc_ptr_d, wr_addr_q, wr_addr_d;
  logic              w_num_q, w_num_d;
  logic              wr_pend_q, wr_pend_d, wr_first_q, wr_first_d, wr_bank_q, wr_bank_d;
  logic              done_q, done_d;

  logic              cfg_ok, psum_ready, accept, last_addr, last_pass;
  logic              drain_start, drain_busy, drain_last, drain_free, d_rd;
  logic [AW-1:0]     d_addr;
  logic              acc_b1, acc_b2, d_b1, d_b2;

  assign cfg_ok = (bus.cfg_tile_len != '0) && (bus.cfg_tile_len <= LW'(PSUM_GBF_DEPTH));

  // With a one-address tile, the next read would hit the address being written.
  assign psum_ready = (state_q == ACC_RUN) && !((tile_len_q == LW'(1)) && wr_pend_q);
  assign accept     = psum_ready && bus.psum_valid;
  assign last_addr  = ({1'b0, acc_ptr_q} == (tile_len_q - LW'(1)));
  assign last_pass  = (pass_cnt_q == (num_pass_q - PW'(1)));
  // Swap is allowed when the drain is idle or finishing its final read now.
  assign drain_free = !drain_busy || drain_last;

  always_comb begin
    state_d     = state_q;
    tile_len_d  = tile_len_q;
    num_pass_d  = num_pass_q;
    num_tile_d  = num_tile_q;
    pass_cnt_d  = pass_cnt_q;
    tile_cnt_d  = tile_cnt_q;
    acc_ptr_d   = acc_ptr_q;
    w_num_d     = w_num_q;
    wr_pend_d   = accept;
    wr_addr_d   = wr_addr_q;
    wr_first_d  = wr_first_q;
    wr_bank_d   = wr_bank_q;
    done_d      = 1'b0;
    drain_start = 1'b0;

    unique case (state_q)
      ACC_IDLE: begin
        if (bus.start && cfg_ok) begin
          tile_len_d = bus.cfg_tile_len;
          num_pass_d = (bus.cfg_num_pass == '0) ? PW'(1) : bus.cfg_num_pass;
          num_tile_d = (bus.cfg_num_tile == '0) ? TW'(1) : bus.cfg_num_tile;
          pass_cnt_d = '0;
          tile_cnt_d = '0;
          acc_ptr_d  = '0;
          state_d    = ACC_RUN;
        end
      end
      ACC_RUN: begin
        if (accept) begin
          wr_addr_d  = acc_ptr_q;
          wr_first_d = (pass_cnt_q == '0);
          wr_bank_d  = w_num_q;
          if (last_addr) begin
            acc_ptr_d = '0;
            if (last_pass) begin
              pass_cnt_d = '0;
              tile_cnt_d = tile_cnt_q + TW'(1);
              state_d    = ACC_SWAP_WAIT;
            end else begin
              pass_cnt_d = pass_cnt_q + PW'(1);
            end
          end else begin
            acc_ptr_d = acc_ptr_q + AW'(1);
          end
        end
      end
      ACC_SWAP_WAIT: begin
        if (drain_free) begin
          w_num_d     = ~w_num_q;
          drain_start = 1'b1;
          state_d     = (tile_cnt_q == num_tile_q) ? ACC_FLUSH : ACC_RUN;
        end
      end
      ACC_FLUSH: begin
        if (!drain_busy) begin
          done_d  = 1'b1;
          state_d = ACC_IDLE;
        end
      end
      default: state_d = ACC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ACC_IDLE;
      tile_len_q <= '0;
      num_pass_q <= '0;
      num_tile_q <= '0;
      pass_cnt_q <= '0;
      tile_cnt_q <= '0;
      acc_ptr_q  <= '0;
      w_num_q    <= BANK1;
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_first_q <= 1'b0;
      wr_bank_q  <= BANK1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tile_len_q <= tile_len_d;
      num_pass_q <= num_pass_d;
      num_tile_q <= num_tile_d;
      pass_cnt_q <= pass_cnt_d;
      tile_cnt_q <= tile_cnt_d;
      acc_ptr_q  <= acc_ptr_d;
      w_num_q    <= w_num_d;
      wr_pend_q  <= wr_pend_d;
      wr_addr_q  <= wr_addr_d;
      wr_first_q <= wr_first_d;
      wr_bank_q  <= wr_bank_d;
      done_q     <= done_d;
    end
  end

  psum_gbf_drain_seq #(
    .PSUM_GBF_ADDR_BITWIDTH(AW)
  ) u_drain (
    .clk_i        (clk),
    .rst_ni       (reset),
    .start_i      (drain_start),
    .tile_len_i   (tile_len_q),
    .drain_ready_i(bus.drain_ready),
    .rd_en_o      (d_rd),
    .rd_addr_o    (d_addr),
    .last_o       (drain_last),
    .busy_o       (drain_busy),
    .drain_valid_o(bus.drain_valid)
  );

  // Accumulate owns bank w_num, drain owns the other, so port b never collides.
  assign acc_b1 = accept && (w_num_q == BANK1);
  assign acc_b2 = accept && (w_num_q == BANK2);
  assign d_b1   = d_rd && (w_num_q == BANK2);
  assign d_b2   = d_rd && (w_num_q == BANK1);

  assign bus.psum_ready     = psum_ready;
  assign bus.r_en1b         = acc_b1 || d_b1;
  assign bus.r_en2b         = acc_b2 || d_b2;
  assign bus.r_addr1b       = acc_b1 ? acc_ptr_q : (d_b1 ? d_addr : '0);
  assign bus.r_addr2b       = acc_b2 ? acc_ptr_q : (d_b2 ? d_addr : '0);
  assign bus.w_en1a         = wr_pend_q && (wr_bank_q == BANK1);
  assign bus.w_en2a         = wr_pend_q && (wr_bank_q == BANK2);
  assign bus.w_addr         = wr_addr_q;
  assign bus.acc_first      = wr_pend_q && wr_first_q;
  assign bus.psum_gbf_w_num = w_num_q;
  assign bus.r_en1b_out     = d_b1;
  assign bus.r_en2b_out     = d_b2;
  assign bus.busy           = (state_q != ACC_IDLE);
  assign bus.done           = done_q;

endmodule

// File: tb/tb_psum_gbf_ctrl.sv
// Scoreboard bench for psum_gbf_ctrl: each job pushes its expected accumulate
// reads/writes and drain reads; a negedge monitor pops and compares them.
module tb_psum_gbf_ctrl;
  import psum_gbf_pkg::*;

  typedef struct packed {
    logic       bank;
    logic [4:0] addr;
    logic       flag;  // acc_first for accumulate entries, last address for drain
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  psum_gbf_ctrl_if #(
    .PSUM_GBF_ADDR_BITWIDTH(5),
    .PASS_CNT_BITWIDTH     (8),
    .TILE_CNT_BITWIDTH     (8)
  ) bus ();

  psum_gbf_ctrl #(
    .PSUM_GBF_ADDR_BITWIDTH(5),
    .PSUM_GBF_DEPTH        (32),
    .PASS_CNT_BITWIDTH     (8),
    .TILE_CNT_BITWIDTH     (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  exp_t acc_rd_q[$];
  exp_t acc_wr_q[$];
  exp_t drain_q[$];
  logic model_wnum = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_acc = 0;
  int done_cnt = 0;
  int last_acc_cyc = 0, last_dlast_cyc = 0, last_dv_cyc = 0;
  int wchg_acc = 0, wchg_dlast = 0, done_gap = 0;
  logic done_busy = 1'b0;
  logic prev_drd = 1'b0, prev_wnum = 1'b0;
  int vmode = 0, rmode = 0;
  logic tog = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Input driver: 0 = always 1, 1 = toggle (ready) / hold 0 (valid), 2 = random.
  initial begin
    bus.start = 1'b0; bus.cfg_tile_len = '0; bus.cfg_num_pass = '0; bus.cfg_num_tile = '0;
    bus.psum_valid = 1'b0; bus.drain_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tog = ~tog;
      bus.psum_valid  = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.drain_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? tog : 1'($urandom_range(0, 1));
    end
  end

  // Monitor / scoreboard consumer.
  initial begin
    exp_t ae, de;
    logic [1:0] exp_ren;
    logic drd;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        prev_drd  = 1'b0;
        prev_wnum = 1'b0;
      end else begin
        exp_ren = 2'b00;
        if (bus.psum_valid && bus.psum_ready) begin
          n_acc++;
          last_acc_cyc = cyc;
          if (acc_rd_q.size() == 0) check_val("acc_extra_beat", 1, 0);
          else begin
            ae = acc_rd_q.pop_front();
            exp_ren[ae.bank] = 1'b1;
            check_val("acc_rd_addr", ae.bank ? bus.r_addr2b : bus.r_addr1b, ae.addr);
          end
        end
        drd = bus.r_en1b_out || bus.r_en2b_out;
        if (drd) begin
          if (drain_q.size() == 0) check_val("drain_extra_read", 1, 0);
          else begin
            de = drain_q.pop_front();
            exp_ren[de.bank] = 1'b1;
            check_val("drain_bank", {bus.r_en2b_out, bus.r_en1b_out}, de.bank ? 2'b10 : 2'b01);
            check_val("drain_addr", de.bank ? bus.r_addr2b : bus.r_addr1b, de.addr);
            if (de.flag) last_dlast_cyc = cyc;
          end
        end
        if (exp_ren != 2'b00 || bus.r_en1b || bus.r_en2b)
          check_val("port_b_en", {bus.r_en2b, bus.r_en1b}, exp_ren);
        if (bus.w_en1a || bus.w_en2a) begin
          if (acc_wr_q.size() == 0) check_val("wr_extra", 1, 0);
          else begin
            ae = acc_wr_q.pop_front();
            check_val("wr_bank", {bus.w_en2a, bus.w_en1a}, ae.bank ? 2'b10 : 2'b01);
            check_val("wr_addr", bus.w_addr, ae.addr);
            check_val("acc_first", bus.acc_first, ae.flag);
          end
        end
        if (prev_drd || bus.drain_valid) check_val("drain_valid", bus.drain_valid, prev_drd);
        if (bus.drain_valid) last_dv_cyc = cyc;
        if (bus.psum_gbf_w_num != prev_wnum) begin
          wchg_acc   = cyc - last_acc_cyc;
          wchg_dlast = cyc - last_dlast_cyc;
        end
        if (bus.done) begin
          done_cnt++;
          done_gap  = cyc - last_dv_cyc;
          done_busy = bus.busy;
        end
        prev_drd  = drd;
        prev_wnum = bus.psum_gbf_w_num;
      end
    end
  end

  task automatic push_job(input int len, input int np, input int nt);
    exp_t e;
    int ep = (np == 0) ? 1 : np;
    int et = (nt == 0) ? 1 : nt;
    for (int t = 0; t < et; t++) begin
      for (int p = 0; p < ep; p++) begin
        for (int a = 0; a < len; a++) begin
          e.bank = model_wnum; e.addr = 5'(a); e.flag = (p == 0);
          acc_rd_q.push_back(e);
          acc_wr_q.push_back(e);
        end
      end
      for (int a = 0; a < len; a++) begin
        e.bank = model_wnum; e.addr = 5'(a); e.flag = (a == len - 1);
        drain_q.push_back(e);
      end
      model_wnum = ~model_wnum;
    end
  endtask

  task automatic pulse_start(input int len, input int np, input int nt);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.cfg_tile_len = 6'(len);
    bus.cfg_num_pass = 8'(np);
    bus.cfg_num_tile = 8'(nt);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_val("done_seen", done_cnt - d0, 1);
    check_val("done_gap_after_dv", done_gap, 1);
    check_val("busy_at_done", done_busy, 0);
    repeat (3) @(negedge clk);
    check_val("done_single", done_cnt - d0, 1);
    check_val("acc_rd_left", acc_rd_q.size(), 0);
    check_val("acc_wr_left", acc_wr_q.size(), 0);
    check_val("drain_left", drain_q.size(), 0);
  endtask

  task automatic run_job(input int len, input int np, input int nt, input int vm, input int rm);
    int d0 = done_cnt;
    vmode = vm;
    rmode = rm;
    push_job(len, np, nt);
    pulse_start(len, np, nt);
    wait_done(d0, 3000);
  endtask

  function automatic logic [31:0] out_vec();
    return {5'd0, bus.psum_ready, bus.r_en1b, bus.r_en2b, bus.r_addr1b, bus.r_addr2b,
            bus.w_en1a, bus.w_en2a, bus.w_addr, bus.acc_first, bus.psum_gbf_w_num,
            bus.r_en1b_out, bus.r_en2b_out, bus.drain_valid, bus.busy, bus.done};
  endfunction

  initial begin
    int a0, n, d0;
    // Reset state
    repeat (3) @(negedge clk);
    check_val("reset_outputs", out_vec(), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle_busy", bus.busy, 0);

    // Basic job: w_num flips two cycles after the final accept
    run_job(4, 2, 1, 0, 0);
    check_val("basic_wnum_delay", wchg_acc, 2);

    // Ping-pong over three tiles
    run_job(4, 1, 3, 0, 0);

    // Drain backpressure: second tile waits for drain of address 7
    run_job(8, 1, 2, 0, 1);
    check_val("bp_swap_after_drain_last", wchg_dlast, 1);

    // One-address tile hazard: ready alternates
    vmode = 0; rmode = 0;
    d0 = done_cnt;
    push_job(1, 4, 1);
    pulse_start(1, 4, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check_val($sformatf("hazard_ready_%0d", i), bus.psum_ready, (i % 2) == 0);
    end
    wait_done(d0, 500);

    // Invalid tile lengths are ignored
    pulse_start(0, 1, 1);
    repeat (3) @(negedge clk);
    check_val("len0_ignored", bus.busy, 0);
    pulse_start(33, 1, 1);
    repeat (3) @(negedge clk);
    check_val("len33_ignored", bus.busy, 0);

    // num_pass = 0 behaves as one pass
    run_job(4, 0, 1, 0, 0);

    // Start while busy is ignored
    vmode = 0; rmode = 0;
    d0 = done_cnt;
    push_job(4, 1, 2);
    pulse_start(4, 1, 2);
    repeat (2) @(posedge clk);
    pulse_start(2, 3, 1);
    wait_done(d0, 1000);

    // Full-depth tile wraps the pointer 31 -> 0
    run_job(32, 2, 1, 0, 0);

    // Random valid/ready stalls
    run_job(5, 3, 3, 2, 2);

    // Reset in the middle of a job
    vmode = 0; rmode = 0;
    push_job(4, 2, 1);
    a0 = n_acc;
    pulse_start(4, 2, 1);
    n = 0;
    while ((n_acc - a0) < 3 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_val("rst_beats_seen", n_acc - a0, 3);
    reset = 1'b0;
    #1;
    check_val("rst_async_outputs", out_vec(), 0);
    check_val("rst_wnum", bus.psum_gbf_w_num, 0);
    acc_rd_q.delete();
    acc_wr_q.delete();
    drain_q.delete();
    model_wnum = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    run_job(4, 2, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/psum_gbf_ctrl.md
Name: psum_gbf_ctrl

Overview:
- Sequencer for the double-buffered partial-sum global buffer (two PSUM_GBF banks, ports a = write and b = read).
- Steers array psum beats into the accumulate bank as read-modify-write, counts passes and tiles, and ping-pongs the banks via psum_gbf_w_num.
- Drains the completed bank to the output side with a ready handshake.
- Sits between the PE array output and psum_gbf_wrapper; the adder and SRAMs stay in the wrapper.

Parameters:
- PSUM_GBF_ADDR_BITWIDTH, 5, bank address width
- PSUM_GBF_DEPTH, 32, bank depth (max tile length)
- PASS_CNT_BITWIDTH, 8, width of pass counter
- TILE_CNT_BITWIDTH, 8, width of tile counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches cfg_* when idle
- cfg_tile_len  in  PSUM_GBF_ADDR_BITWIDTH+1  addresses per pass, 1..PSUM_GBF_DEPTH
- cfg_num_pass  in  PASS_CNT_BITWIDTH  accumulation passes per tile (0 treated as 1)
- cfg_num_tile  in  TILE_CNT_BITWIDTH  tiles per job (0 treated as 1)
- psum_valid  in  1  array presents a psum beat
- psum_ready  out  1  beat accepted when psum_valid & psum_ready
- r_en1b, r_en2b  out  1  bank read enables (accumulate read or drain read)
- r_addr1b, r_addr2b  out  PSUM_GBF_ADDR_BITWIDTH  bank read addresses
- w_en1a, w_en2a  out  1  bank write enables
- w_addr  out  PSUM_GBF_ADDR_BITWIDTH  shared write address
- acc_first  out  1  wrapper adds zero instead of read data (first pass)
- psum_gbf_w_num  out  1  accumulate bank select: 0 = bank1, 1 = bank2
- drain_ready  in  1  downstream can take a word next cycle
- r_en1b_out, r_en2b_out  out  1  drain read issued on bank1 / bank2
- drain_valid  out  1  drained word valid on r_data (one cycle after drain read)
- busy  out  1  job in progress
- done  out  1  one-cycle pulse when the last tile is fully drained

Behaviour:
- Reset values: all outputs 0; psum_gbf_w_num=0; all counters 0; both FSMs idle.
- Reset is honoured mid-job: the job is abandoned and no further enables are issued.
- Accumulate FSM states: IDLE, ACC, SWAP_WAIT, FLUSH.
- IDLE: start with cfg_tile_len in 1..DEPTH latches config and moves to ACC; busy=1.
  - start with an invalid tile_len is ignored.
  - start when busy is ignored.
- ACC: psum_ready=1, except as noted under hazards below.
  - Beat accepted at cycle t:
    - Combinational read of the accumulate bank at acc_ptr in cycle t (r_en on bank selected by w_num, r_addr=acc_ptr).
    - At t+1: w_en on the same bank, w_addr=acc_ptr registered at t, acc_first = (pass_cnt==0) registered at t.
  - acc_ptr increments per accepted beat and wraps to 0 at tile_len-1, incrementing pass_cnt.
- Hazard, tile_len==1: psum_ready deasserts in the cycle after each accepted beat (no read-during-write on one address).
- Tile complete: final beat (last address, last pass) accepted at t; its write happens at t+1.
  - Drain idle: w_num toggles at the t+1 edge (visible t+2), drain starts on the completed bank at t+2, and the accumulate FSM returns to ACC, or to FLUSH if that was the last tile.
  - Drain busy: enter SWAP_WAIT, psum_ready=0; swap in the cycle drain finishes.
- FLUSH: psum_ready=0; wait for drain idle, then pulse done, go to IDLE, busy=0.
- Drain FSM states: D_IDLE, D_RUN.
  - D_RUN: per cycle with drain_ready=1, assert r_enXb_out and r_enXb on the non-accumulate bank, addr=d_ptr, d_ptr++.
  - drain_ready=0: no read that cycle.
  - drain_valid follows each drain read by exactly one cycle.
  - After address tile_len-1 is read, return to D_IDLE; d_ptr resets to 0.
- A bank's port b is never driven by accumulate and drain in the same cycle: accumulate always uses bank w_num, drain uses bank ~w_num.

Decomposition:
- Package psum_gbf_pkg: FSM state encodings (ACC_IDLE, ACC_RUN, ACC_SWAP_WAIT, ACC_FLUSH, D_IDLE, D_RUN) and bank-select constants BANK1=0, BANK2=1.
- One natural sub-module: psum_gbf_drain_seq (drain FSM, d_ptr, drain_valid pipeline).
- The top module holds the accumulate FSM, counters and bank muxing.

Test Plan:
- Basic job: tile_len=4, num_pass=2, num_tile=1, psum_valid=1 continuously, drain_ready=1 -> 8 beats accepted; w_addr 0,1,2,3,0,1,2,3; acc_first=1 for the first 4 writes, 0 for the next 4; w_num 0→1 two cycles after the last accept; r_en1b_out on 4 consecutive cycles with addr 0..3; done pulses one cycle after the last drain_valid.
- Ping-pong: tile_len=4, num_pass=1, num_tile=3 -> banks alternate 1,2,1; drain of tile k overlaps accumulation of tile k+1; no cycle has r_en1b asserted for both accumulate and drain.
- Drain backpressure: tile_len=8, num_tile=2, drain_ready toggles 1,0 -> second tile finishes first; SWAP_WAIT holds psum_ready=0 until drain addr 7 is read, then swap.
- Hazard: tile_len=1, num_pass=4 -> psum_ready pattern 1,0,1,0…; 4 writes to addr 0; acc_first only on the first.
- Config edges: tile_len=0 start ignored (busy stays 0); num_pass=0 behaves as 1; start while busy ignored; tile_len=32 wraps acc_ptr 31→0.
- Reset mid-job: assert reset low during ACC at beat 3 -> all outputs 0 asynchronously; w_num=0; after release a new start runs cleanly from addr 0.
